// File: rtl/combo_lock_pkg.sv
// Shared types and constants for the switch-entry combination lock.
// The state encoding doubles as the display code driven on state_code.
package combo_lock_pkg;

    localparam int STATE_W = 4;
    localparam int DIGIT_W = 4;
    localparam int CNT_W   = 3;
    localparam int TRIES_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 4'd0,
        S_ENTRY   = 4'd1,
        S_CHECK   = 4'd2,
        S_OPEN    = 4'd3,
        S_FAIL    = 4'd4,
        S_LOCKOUT = 4'd5,
        S_PROG    = 4'd6
    } state_t;

    // Thermometer code with the lowest n bits set (n digits taken so far).
    function automatic logic [3:0] thermo(input logic [CNT_W-1:0] n);
        logic [3:0] t;
        t = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(n)) t[i] = 1'b1;
        end
        return t;
    endfunction

endpackage

// File: rtl/combo_lock_ctrl_btn_pulse.sv
// Button conditioner: two-flop synchronizer followed by a rising-edge
// detector. A held button yields a single one-cycle pulse; the pulse is
// visible to the consumer on the third clock edge after the async edge.
module btn_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    // Synchronize the raw level and keep one cycle of history for the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            // NOTE: non-blocking so each flop takes its neighbour's old value
            // and the chain really is three stages deep.
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign pulse = sync2 & ~prev;

endmodule

// File: rtl/combo_lock_ctrl.sv
// Combination lock sequencer: captures DIGITS switch digits on Enter,
// compares against the stored code, and drives open / fail / lockout.
// Optional feature macro: COMBO_LOCK_PROGRAM_EN enables re-programming
// the code from the OPEN state (PROG state). Without it the code is the
// constant DEFAULT_CODE.
module combo_lock_ctrl
    import combo_lock_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned FAIL_CYCLES    = 50_000_000,
    parameter int unsigned OPEN_CYCLES    = 500_000_000,
    parameter int unsigned LOCKOUT_CYCLES = 1_000_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_enter,
    input  logic               btn_clear,
    input  logic [DIGIT_W-1:0] sw_digit,
    output logic [STATE_W-1:0] state_code,
    output logic [3:0]         led,
    output logic               unlocked
);

    localparam int unsigned CODE_W  = DIGITS * DIGIT_W;
    localparam int unsigned MAX_FO  = (FAIL_CYCLES > OPEN_CYCLES) ? FAIL_CYCLES : OPEN_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_FO > LOCKOUT_CYCLES) ? MAX_FO : LOCKOUT_CYCLES;
    localparam int          TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // Timer is loaded with N-1 and the state exits on reaching 0: N cycles.
    localparam logic [TIMER_W-1:0] FAIL_LOAD    = TIMER_W'(FAIL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OPEN_LOAD    = TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);

    localparam logic [CNT_W-1:0]   LAST_CNT   = CNT_W'(DIGITS - 1);
    localparam logic [TRIES_W-1:0] TRIES_MAX  = TRIES_W'(MAX_TRIES);
    // Digit 0 sits in the top nibble, so shorter codes use the top digits.
    localparam logic [CODE_W-1:0]  RESET_CODE = DEFAULT_CODE[15 -: CODE_W];

    state_t               state;
    logic [CODE_W-1:0]    digits;
    logic [CNT_W-1:0]     cnt;
    logic [TRIES_W-1:0]   tries;
    logic [TRIES_W-1:0]   tries_inc;
    logic [TIMER_W-1:0]   timer;
    logic [CODE_W-1:0]    stored_code;
    logic [CODE_W-1:0]    digits_shift;
    logic                 enter_p;
    logic                 clear_p;
    logic                 enter_take;

    btn_pulse u_enter (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_enter),
        .pulse (enter_p)
    );

    btn_pulse u_clear (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_clear),
        .pulse (clear_p)
    );

    // Clear has priority: an Enter arriving in the same cycle is dropped.
    assign enter_take   = enter_p & ~clear_p;
    assign digits_shift = {digits[CODE_W-DIGIT_W-1:0], sw_digit};
    assign tries_inc    = (tries == TRIES_MAX) ? tries : tries + 1'b1;

`ifndef COMBO_LOCK_PROGRAM_EN
    assign stored_code = RESET_CODE;
`endif

    // Main FSM with shared dwell timer, digit shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            digits     <= '0;
            cnt        <= '0;
            tries      <= '0;
            timer      <= '0;
            state_code <= '0;
            led        <= '0;
            unlocked   <= 1'b0;
`ifdef COMBO_LOCK_PROGRAM_EN
            stored_code <= RESET_CODE;
`endif
        end else begin
            // Outputs follow the state register, one cycle behind it.
            state_code <= state;
            unlocked   <= (state == S_OPEN);
            case (state)
                S_ENTRY:            led <= thermo(cnt);
                S_OPEN:             led <= 4'hF;
                S_FAIL, S_LOCKOUT:  led <= {1'b0, tries};
                default:            led <= 4'h0;
            endcase

            case (state)
                S_IDLE: begin
                    if (enter_take) begin
                        digits <= digits_shift;
                        cnt    <= CNT_W'(1);
                        state  <= S_ENTRY;
                    end
                end

                S_ENTRY: begin
                    if (clear_p) begin
                        digits <= '0;
                        cnt    <= '0;
                        state  <= S_IDLE;
                    end else if (enter_take) begin
                        digits <= digits_shift;
                        cnt    <= cnt + 1'b1;
                        if (cnt == LAST_CNT) state <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (digits == stored_code) begin
                        tries <= '0;
                        timer <= OPEN_LOAD;
                        state <= S_OPEN;
                    end else begin
                        tries <= tries_inc;
                        if (tries_inc == TRIES_MAX) begin
                            timer <= LOCKOUT_LOAD;
                            state <= S_LOCKOUT;
                        end else begin
                            timer <= FAIL_LOAD;
                            state <= S_FAIL;
                        end
                    end
                end

                S_FAIL: begin
                    if (timer == '0) begin
                        digits <= '0;
                        cnt    <= '0;
                        state  <= S_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                S_OPEN: begin
                    if (clear_p || timer == '0) begin
                        digits <= '0;
                        cnt    <= '0;
                        state  <= S_IDLE;
                    end
`ifdef COMBO_LOCK_PROGRAM_EN
                    else if (enter_take) begin
                        digits <= '0;
                        cnt    <= '0;
                        state  <= S_PROG;
                    end
`endif
                    else begin
                        timer <= timer - 1'b1;
                    end
                end

                S_LOCKOUT: begin
                    if (timer == '0) begin
                        tries  <= '0;
                        digits <= '0;
                        cnt    <= '0;
                        state  <= S_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

`ifdef COMBO_LOCK_PROGRAM_EN
                S_PROG: begin
                    if (clear_p) begin
                        digits <= '0;
                        cnt    <= '0;
                        state  <= S_IDLE;
                    end else if (enter_take) begin
                        if (cnt == LAST_CNT) begin
                            stored_code <= digits_shift;
                            digits      <= '0;
                            cnt         <= '0;
                            state       <= S_IDLE;
                        end else begin
                            digits <= digits_shift;
                            cnt    <= cnt + 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    digits <= '0;
                    cnt    <= '0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Directed testbench for combo_lock_ctrl. Define COMBO_LOCK_PROGRAM_EN for
// both bench and RTL to exercise code programming.
module tb_combo_lock_ctrl;

    logic       clk;
    logic       rst_n;
    logic       btn_enter;
    logic       btn_clear;
    logic [3:0] sw_digit;
    logic [3:0] state_code;
    logic [3:0] led;
    logic       unlocked;

    int checks = 0;
    int errors = 0;

    combo_lock_ctrl #(
        .DIGITS         (4),
        .DEFAULT_CODE   (16'h1234),
        .MAX_TRIES      (3),
        .FAIL_CYCLES    (8),
        .OPEN_CYCLES    (20),
        .LOCKOUT_CYCLES (40)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_enter  (btn_enter),
        .btn_clear  (btn_clear),
        .sw_digit   (sw_digit),
        .state_code (state_code),
        .led        (led),
        .unlocked   (unlocked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic press(input logic en, input logic cl, input logic [3:0] d, input int hold);
        sw_digit  = d;
        btn_enter = en;
        btn_clear = cl;
        repeat (hold) @(negedge clk);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic try_code(input logic [15:0] c);
        press(1'b1, 1'b0, c[15:12], 4);
        press(1'b1, 1'b0, c[11:8], 4);
        press(1'b1, 1'b0, c[7:4], 4);
        press(1'b1, 1'b0, c[3:0], 4);
    endtask

    // Enter a code and measure how many cycles state_code shows sc.
    task automatic measure(input logic [15:0] c, input logic [3:0] sc, output int dwell,
                           output logic [3:0] led_seen, output logic unl_seen, output int chk);
        press(1'b1, 1'b0, c[15:12], 4);
        press(1'b1, 1'b0, c[11:8], 4);
        press(1'b1, 1'b0, c[7:4], 4);
        dwell = 0;
        chk = 0;
        led_seen = 4'h0;
        unl_seen = 1'b0;
        sw_digit = c[3:0];
        btn_enter = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 3) btn_enter = 1'b0;
            if (state_code == 4'd2) chk++;
            if (state_code == sc) begin
                if (dwell == 0) begin
                    led_seen = led;
                    unl_seen = unlocked;
                end
                dwell++;
            end else if (dwell > 0) begin
                break;
            end
        end
        btn_enter = 1'b0;
    endtask

    task automatic test_reset();
        int dwell, chk;
        logic [3:0] ls;
        logic us;
        rst_n = 1'b0;
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        sw_digit = 4'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({state_code, led, unlocked} !== 9'h0) begin
            errors++;
            $display("FAIL reset_outputs: got sc=%h led=%h unl=%b, need all 0", state_code, led, unlocked);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (state_code !== 4'd0 || led !== 4'h0 || unlocked !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got sc=%h led=%h unl=%b, need 0/0/0", state_code, led, unlocked);
        end
    endtask

    task automatic test_open();
        int dwell, chk;
        logic [3:0] ls;
        logic us;
        do_reset();
        measure(16'h1234, 4'd3, dwell, ls, us, chk);
        checks++;
        if (chk !== 1) begin
            errors++;
            $display("FAIL check_one_cycle: got %0d cycles, need 1", chk);
        end
        checks++;
        if (ls !== 4'hF || us !== 1'b1) begin
            errors++;
            $display("FAIL open_outputs: got led=%h unl=%b, need F/1", ls, us);
        end
        checks++;
        if (dwell !== 20) begin
            errors++;
            $display("FAIL open_dwell: got %0d cycles, need 20", dwell);
        end
        checks++;
        if (state_code !== 4'd0 || unlocked !== 1'b0 || led !== 4'h0) begin
            errors++;
            $display("FAIL relock_idle: got sc=%h unl=%b led=%h, need 0/0/0", state_code, unlocked, led);
        end
    endtask

    task automatic test_fail();
        int dwell, chk;
        logic [3:0] ls;
        logic us;
        do_reset();
        measure(16'h1235, 4'd4, dwell, ls, us, chk);
        checks++;
        if (ls !== 4'h1 || us !== 1'b0) begin
            errors++;
            $display("FAIL fail_led: got led=%h unl=%b, need 1/0", ls, us);
        end
        checks++;
        if (dwell !== 8) begin
            errors++;
            $display("FAIL fail_dwell: got %0d cycles, need 8", dwell);
        end
        measure(16'h1234, 4'd3, dwell, ls, us, chk);
        checks++;
        if (dwell !== 20 || us !== 1'b1) begin
            errors++;
            $display("FAIL open_after_fail: got dwell=%0d unl=%b, need 20/1", dwell, us);
        end
        // tries was cleared by the match, so the next failure counts as 1.
        measure(16'h9999, 4'd4, dwell, ls, us, chk);
        checks++;
        if (ls !== 4'h1) begin
            errors++;
            $display("FAIL tries_cleared: got led=%h, need 1", ls);
        end
    endtask

    task automatic test_lockout();
        int dwell, chk, rest;
        logic [3:0] ls;
        logic us;
        do_reset();
        measure(16'h0000, 4'd4, dwell, ls, us, chk);
        measure(16'h4321, 4'd4, dwell, ls, us, chk);
        checks++;
        if (ls !== 4'h2) begin
            errors++;
            $display("FAIL second_fail_led: got %h, need 2", ls);
        end
        try_code(16'h1243);
        checks++;
        if (state_code !== 4'd5 || led !== 4'h3 || unlocked !== 1'b0) begin
            errors++;
            $display("FAIL lockout_outputs: got sc=%h led=%h unl=%b, need 5/3/0", state_code, led, unlocked);
        end
        press(1'b1, 1'b0, 4'h1, 4);
        press(1'b1, 1'b0, 4'h2, 4);
        checks++;
        if (state_code !== 4'd5 || led !== 4'h3) begin
            errors++;
            $display("FAIL lockout_ignores_enter: got sc=%h led=%h, need 5/3", state_code, led);
        end
        // 4 + 16 lockout cycles have elapsed; 20 should remain.
        rest = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (state_code == 4'd5) rest++;
            else break;
        end
        checks++;
        if (rest !== 20 || state_code !== 4'd0 || led !== 4'h0) begin
            errors++;
            $display("FAIL lockout_exit: got rest=%0d sc=%h led=%h, need 20/0/0", rest, state_code, led);
        end
        measure(16'h1234, 4'd3, dwell, ls, us, chk);
        checks++;
        if (dwell !== 20 || ls !== 4'hF) begin
            errors++;
            $display("FAIL open_after_lockout: got dwell=%0d led=%h, need 20/F", dwell, ls);
        end
    endtask

    task automatic test_clear();
        do_reset();
        press(1'b1, 1'b0, 4'h1, 4);
        press(1'b1, 1'b0, 4'h2, 4);
        checks++;
        if (state_code !== 4'd1 || led !== 4'b0011) begin
            errors++;
            $display("FAIL entry_two_digits: got sc=%h led=%b, need 1/0011", state_code, led);
        end
        press(1'b0, 1'b1, 4'h0, 4);
        checks++;
        if (state_code !== 4'd0 || led !== 4'h0) begin
            errors++;
            $display("FAIL clear_to_idle: got sc=%h led=%h, need 0/0", state_code, led);
        end
        press(1'b1, 1'b0, 4'h3, 4);
        press(1'b1, 1'b0, 4'h4, 4);
        checks++;
        if (state_code !== 4'd1 || led !== 4'b0011) begin
            errors++;
            $display("FAIL entry_after_clear: got sc=%h led=%b, need 1/0011", state_code, led);
        end
        press(1'b1, 1'b1, 4'h5, 4);
        checks++;
        if (state_code !== 4'd0 || led !== 4'h0) begin
            errors++;
            $display("FAIL clear_beats_enter: got sc=%h led=%h, need 0/0", state_code, led);
        end
    endtask

    task automatic test_hold_and_async_reset();
        do_reset();
        press(1'b1, 1'b0, 4'h1, 100);
        checks++;
        if (state_code !== 4'd1 || led !== 4'b0001) begin
            errors++;
            $display("FAIL held_button_one_digit: got sc=%h led=%b, need 1/0001", state_code, led);
        end
        press(1'b1, 1'b0, 4'h2, 4);
        press(1'b1, 1'b0, 4'h3, 4);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (state_code !== 4'd0 || led !== 4'h0 || unlocked !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_entry: got sc=%h led=%h unl=%b, need 0/0/0", state_code, led, unlocked);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        try_code(16'h1234);
        checks++;
        if (unlocked !== 1'b1 || state_code !== 4'd3) begin
            errors++;
            $display("FAIL open_after_reset: got unl=%b sc=%h, need 1/3", unlocked, state_code);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (unlocked !== 1'b0 || state_code !== 4'd0 || led !== 4'h0) begin
            errors++;
            $display("FAIL async_reset_open: got unl=%b sc=%h led=%h, need 0/0/0", unlocked, state_code, led);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

`ifdef COMBO_LOCK_PROGRAM_EN
    task automatic test_program();
        int dwell, chk;
        logic [3:0] ls;
        logic us;
        do_reset();
        try_code(16'h1234);
        press(1'b1, 1'b0, 4'h0, 4);
        checks++;
        if (state_code !== 4'd6 || unlocked !== 1'b0) begin
            errors++;
            $display("FAIL enter_prog: got sc=%h unl=%b, need 6/0", state_code, unlocked);
        end
        try_code(16'h9876);
        checks++;
        if (state_code !== 4'd0 || unlocked !== 1'b0) begin
            errors++;
            $display("FAIL prog_done_idle: got sc=%h unl=%b, need 0/0", state_code, unlocked);
        end
        measure(16'h1234, 4'd4, dwell, ls, us, chk);
        checks++;
        if (dwell !== 8) begin
            errors++;
            $display("FAIL old_code_fails: got fail dwell=%0d, need 8", dwell);
        end
        measure(16'h9876, 4'd3, dwell, ls, us, chk);
        checks++;
        if (dwell !== 20) begin
            errors++;
            $display("FAIL new_code_opens: got open dwell=%0d, need 20", dwell);
        end
        do_reset();
        measure(16'h1234, 4'd3, dwell, ls, us, chk);
        checks++;
        if (dwell !== 20) begin
            errors++;
            $display("FAIL reset_restores_code: got open dwell=%0d, need 20", dwell);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        sw_digit = 4'h0;
        test_reset();
        test_open();
        test_fail();
        test_lockout();
        test_clear();
        test_hold_and_async_reset();
`ifdef COMBO_LOCK_PROGRAM_EN
        test_program();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
